multiply_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one unsigned N×N Multiply datapath between M requesters. It accepts one operand pair at a time over per-requester valid/ready handshakes and holds the operands stable while the multiplier settles. The multiplier is allowed LATENCY cycles, treated as a multicycle path. The 2N-bit product is returned on a single response channel tagged with the requester index. It sits between the fixed-point arithmetic clients and the shared multiplier instance.

---
 rtl/multiply_arbiter_if.sv | 28 ++
 rtl/multiply_arbiter.sv | 139 +++++++++++++
 tb/tb_multiply_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiply_arbiter_if.sv
// Request/response bundle between M requesters and the shared multiplier
// sequencer. The master side is the client population, the slave side is
// the arbiter.
interface multiply_arbiter_if #(
  parameter int N = 32,
  parameter int M = 4
);
  localparam int IDW = $clog2(M);

  logic [M-1:0]   req_valid;
  logic [M-1:0]   req_ready;
  logic [M*N-1:0] req_a;
  logic [M*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*N-1:0] rsp_data;
  logic [IDW-1:0] rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/multiply_arbiter.sv
// Round-robin arbiter/sequencer in front of one shared unsigned N x N
// multiplier. One operand pair is in flight at a time: it is captured on
// grant, held stable for LATENCY cycles while the combinational multiplier
// settles (multicycle path), and the 2N-bit product is returned tagged with
// the requester index.
module multiply_arbiter #(
  parameter int N       = 32,
  parameter int M       = 4,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  multiply_arbiter_if.slave bus,
  output logic              busy
);

  localparam int IDW = $clog2(M);
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_vld;
  logic             accept;
  logic [IDW-1:0]   tag;
  logic [CW-1:0]    cnt;
  logic [N-1:0]     opa_p0;
  logic [N-1:0]     opb_p0;
  logic [2*N-1:0]   prod_p0;
  logic [2*N-1:0]   rsp_data_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_valid_q;
  logic             busy_q;

  // Full-width unsigned product; operands are zero-extended so the top
  // half is never lost.
  function automatic logic [2*N-1:0] full_product(input logic [N-1:0] a,
                                                  input logic [N-1:0] b);
    return {{N{1'b0}}, a} * {{N{1'b0}}, b};
  endfunction

  // Rotating-priority search starting just after the last served requester.
  always_comb begin
    logic [IDW-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 1; k <= M; k++) begin
      idx = IDW'((int'(last_grant) + k) % M);
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // A grant is only offered from IDLE and never while reset is asserted.
  assign accept = grant_vld && (state == IDLE) && !rst;

  // One-hot ready toward the granted requester.
  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  // ---- stage p0: operand registers, held for the whole multicycle window
  always_ff @(posedge clk) begin
    if (accept) begin
      opa_p0 <= bus.req_a[int'(grant_idx)*N +: N];
      opb_p0 <= bus.req_b[int'(grant_idx)*N +: N];
    end
  end

  // Shared multiplier: LATENCY cycles are allotted between capture and use.
  assign prod_p0 = full_product(opa_p0, opb_p0);

  // Sequencer FSM: grant, count down the multiplier window, hold response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= IDW'(M - 1);
      tag         <= '0;
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant_idx;
            tag        <= grant_idx;
            cnt        <= CW'(LATENCY - 1);
            busy_q     <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          if (cnt == '0) begin
            rsp_data_q  <= prod_p0;
            rsp_id_q    <= tag;
            rsp_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // ---- stage p1: registered response toward the consumer
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_multiply_arbiter.sv
// Bench for multiply_arbiter: a LATENCY=1 instance exercised with directed
// literal expectations, and a LATENCY=3 instance checked every cycle against
// a transaction-level reference model under directed and random traffic.
module tb_multiply_arbiter;

  localparam int N    = 32;
  localparam int M    = 4;
  localparam int LAT3 = 3;

  logic clk;
  logic rst;
  logic busy1;
  logic busy3;

  int checks = 0;
  int errors = 0;
  int acc3_cnt = 0;
  int rsp3_cnt = 0;

  multiply_arbiter_if #(.N(N), .M(M)) bus1 ();
  multiply_arbiter_if #(.N(N), .M(M)) bus3 ();

  multiply_arbiter #(.N(N), .M(M), .LATENCY(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus1),
    .busy (busy1)
  );

  multiply_arbiter #(.N(N), .M(M), .LATENCY(LAT3)) dut3 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus3),
    .busy (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom % 8)
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- reference model for the LATENCY=3 instance ----------------
  // A job is either absent, ageing through the multiplier window, or
  // presented (age == LAT3) until the consumer takes it.
  bit          model_ok = 1'b0;
  bit          m_job;
  int          m_age;
  int          m_last;
  logic [63:0] m_pend;
  int          m_pid;
  logic [63:0] m_data;
  int          m_id;

  always @(negedge clk) begin : cmp
    logic [3:0] exp_rdy;
    int g;
    int idx;
    exp_rdy = '0;
    g = -1;
    if (!rst && !m_job && model_ok) begin
      for (int k = 1; k <= M; k++) begin
        idx = (m_last + k) % M;
        if (g < 0 && bus3.req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;

    if (model_ok) begin
      check("req_ready", 64'(bus3.req_ready), 64'(exp_rdy));
      check("rsp_valid", 64'(bus3.rsp_valid), 64'(m_job && m_age == LAT3));
      check("busy", 64'(busy3), 64'(m_job));
      check("rsp_data", bus3.rsp_data, m_data);
      check("rsp_id", 64'(bus3.rsp_id), 64'(m_id));
      if (bus3.rsp_valid && bus3.rsp_ready) rsp3_cnt++;
    end

    if (rst) begin
      m_job    <= 1'b0;
      m_age    <= 0;
      m_last   <= M - 1;
      m_data   <= '0;
      m_id     <= 0;
      model_ok <= 1'b1;
    end else if (model_ok) begin
      if (!m_job) begin
        if (g >= 0) begin
          m_job  <= 1'b1;
          m_age  <= 0;
          m_pend <= 64'(bus3.req_a[g*N +: N]) * 64'(bus3.req_b[g*N +: N]);
          m_pid  <= g;
          m_last <= g;
        end
      end else if (m_age < LAT3) begin
        m_age <= m_age + 1;
        if (m_age + 1 == LAT3) begin
          m_data <= m_pend;
          m_id   <= m_pid;
        end
      end else if (bus3.rsp_ready) begin
        m_job <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for any acceptance on the LATENCY=3 instance; returns
  // just after the accepting edge.
  task automatic wait_accept3(input string name);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if ((bus3.req_valid & bus3.req_ready) != '0) got = 1'b1;
      tick();
    end
    check(name, 64'(got), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fa [M];
    logic [31:0] fb [M];
    logic [3:0]  acc;
    int          stall_cnt;
    int          r;

    rst = 1'b1;
    bus1.req_valid = 4'hF;
    bus1.req_a = '0;
    bus1.req_b = '0;
    bus1.rsp_ready = 1'b1;
    bus3.req_valid = '0;
    bus3.req_a = '0;
    bus3.req_b = '0;
    bus3.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    // Reset values, with every requester asserting valid.
    @(negedge clk);
    check("rst_req_ready", 64'(bus1.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus1.rsp_valid), 64'd0);
    check("rst_rsp_data", bus1.rsp_data, 64'd0);
    check("rst_rsp_id", 64'(bus1.rsp_id), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    tick();
    rst = 1'b0;

    // Single request from requester 2: 3 * 5.
    bus1.req_valid = 4'b0100;
    bus1.req_a[2*N +: N] = 32'd3;
    bus1.req_b[2*N +: N] = 32'd5;
    @(negedge clk);
    check("single_ready", 64'(bus1.req_ready), 64'b0100);
    check("single_busy_idle", 64'(busy1), 64'd0);
    tick();
    bus1.req_valid = '0;
    @(negedge clk);
    check("single_busy_calc", 64'(busy1), 64'd1);
    check("single_valid_calc", 64'(bus1.rsp_valid), 64'd0);
    tick();
    @(negedge clk);
    check("single_rsp_valid", 64'(bus1.rsp_valid), 64'd1);
    check("single_rsp_data", bus1.rsp_data, 64'd15);
    check("single_rsp_id", 64'(bus1.rsp_id), 64'd2);
    check("single_busy_done", 64'(busy1), 64'd1);
    tick();
    @(negedge clk);
    check("single_after_hs_valid", 64'(bus1.rsp_valid), 64'd0);
    check("single_after_hs_busy", 64'(busy1), 64'd0);
    tick();

    // Fairness: all requesters held valid after a reset, one accept per 3 cycles.
    for (int i = 0; i < M; i++) begin
      fa[i] = 32'h1000 + 32'(i);
      fb[i] = 32'h20 + 32'(i * 7);
      bus1.req_a[i*N +: N] = fa[i];
      bus1.req_b[i*N +: N] = fb[i];
    end
    bus1.req_valid = 4'hF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      r = (c / 3) % M;
      if (c % 3 == 0) check("fair_grant", 64'(bus1.req_ready), 64'(4'b0001 << r));
      else            check("fair_no_grant", 64'(bus1.req_ready), 64'd0);
      if (c % 3 == 2) begin
        check("fair_rsp_valid", 64'(bus1.rsp_valid), 64'd1);
        check("fair_rsp_id", 64'(bus1.rsp_id), 64'(r));
        check("fair_rsp_data", bus1.rsp_data, 64'(fa[r]) * 64'(fb[r]));
      end
      tick();
    end
    bus1.req_valid = '0;

    // Maximum operands on the LATENCY=3 instance with 14 cycles of backpressure.
    bus3.rsp_ready = 1'b0;
    bus3.req_a[2*N +: N] = 32'hFFFF_FFFF;
    bus3.req_b[2*N +: N] = 32'hFFFF_FFFF;
    bus3.req_valid = 4'b0100;
    wait_accept3("max_accept");
    bus3.req_valid = '0;
    stall_cnt = 0;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      if (bus3.rsp_valid) begin
        stall_cnt++;
        check("max_rsp_data", bus3.rsp_data, 64'hFFFF_FFFE_0000_0001);
      end
      tick();
    end
    check("stall_done_cycles", 64'(stall_cnt), 64'd11);
    bus3.rsp_ready = 1'b1;
    repeat (3) tick();

    // Serve requester 1, then reset in the 2nd CALC cycle of requester 3.
    bus3.req_a[1*N +: N] = rand_op();
    bus3.req_b[1*N +: N] = rand_op();
    bus3.req_valid = 4'b0010;
    wait_accept3("pre_reset_accept1");
    bus3.req_valid = '0;
    repeat (5) tick();
    bus3.req_a[3*N +: N] = rand_op();
    bus3.req_b[3*N +: N] = rand_op();
    bus3.req_valid = 4'b1000;
    wait_accept3("pre_reset_accept3");
    bus3.req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus3.req_valid = 4'b0011;
    @(negedge clk);
    check("post_rst_busy", 64'(busy3), 64'd0);
    check("post_rst_rsp_valid", 64'(bus3.rsp_valid), 64'd0);
    check("post_rst_rsp_data", bus3.rsp_data, 64'd0);
    check("post_rst_rsp_id", 64'(bus3.rsp_id), 64'd0);
    check("post_rst_grant", 64'(bus3.req_ready), 64'b0001);
    tick();
    bus3.req_valid = 4'b0010;
    repeat (12) tick();
    bus3.req_valid = '0;
    repeat (6) tick();

    // Random traffic against the model.
    acc3_cnt = 0;
    rsp3_cnt = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      acc = bus3.req_valid & bus3.req_ready;
      tick();
      for (int i = 0; i < M; i++) begin
        if (acc[i]) begin
          acc3_cnt++;
          if ($urandom % 2 == 0) begin
            bus3.req_a[i*N +: N] = rand_op();
            bus3.req_b[i*N +: N] = rand_op();
          end else begin
            bus3.req_valid[i] = 1'b0;
          end
        end else if (!bus3.req_valid[i]) begin
          if ($urandom % 4 == 0) begin
            bus3.req_a[i*N +: N] = rand_op();
            bus3.req_b[i*N +: N] = rand_op();
            bus3.req_valid[i] = 1'b1;
          end
        end else if ($urandom % 64 == 0) begin
          bus3.req_valid[i] = 1'b0;
        end
      end
      bus3.rsp_ready = ($urandom % 4) != 0;
    end
    @(negedge clk);
    acc = bus3.req_valid & bus3.req_ready;
    tick();
    for (int i = 0; i < M; i++) if (acc[i]) acc3_cnt++;
    bus3.req_valid = '0;
    bus3.rsp_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("accepts_vs_responses", 64'(rsp3_cnt), 64'(acc3_cnt));
    check("random_traffic_seen", 64'(acc3_cnt > 100), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
